dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Data-memory controller directly downstream of the memory stage. Consumes
//  mem_read/mem_write/mem_addr/mem_data and drives an 8-bit byte-wide
//  synchronous RAM port. It serialises each 32-bit little-endian Y86 access
//  into 4 byte beats and returns valM. It holds the pipeline via stall_o and
//  flags illegal accesses on err_o.
// PARAMETERS
//  MEM_BYTES  65536  RAM size in bytes; legal word address is addr <= MEM_BYTES-4
//  RD_LAT     1      cycles from ram_re high to ram_rdata valid (>=1)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  mem_read   in   1   read request (level, held while stall_o=1)
//  mem_write  in   1   write request (level, held while stall_o=1)
//  mem_addr   in   32  byte address of word access
//  mem_data   in   32  write data
//  valM_o     out  32  read result
//  stall_o    out  1   pipeline hold while an access is in progress
//  err_o      out  1   1-cycle pulse: illegal access rejected
//  ram_addr   out  32  RAM byte address
//  ram_wdata  out  8   RAM write byte
//  ram_we     out  1   RAM write strobe, one byte per cycle
//  ram_re     out  1   RAM read strobe
//  ram_rdata  in   8   RAM read byte, valid RD_LAT cycles after ram_re
// BEHAVIOUR
//  - Reset: state=IDLE. valM_o, ram_addr, ram_wdata = 0. ram_we, ram_re, err_o = 0.
//  - FSM states: IDLE, XFER, WAIT, DONE.
//  - Beat counter k runs 0..3. A second counter runs 0..RD_LAT-1.
//  - IDLE, no request: stay in IDLE, stall_o=0.
//  - IDLE, exactly one of mem_read/mem_write set, mem_addr <= MEM_BYTES-4:
//    latch addr, data and op; k=0; go to XFER; stall_o=1 (combinational).
//  - IDLE, illegal request (both read and write set, or addr > MEM_BYTES-4):
//    err_o=1 in the next cycle only; no RAM strobe; stall_o=0; stay in IDLE.
//  - Address bound uses 33-bit arithmetic, so no wrap-around at 0xFFFFFFFD+.
//  - XFER write: ram_we=1, ram_addr=addr+k, ram_wdata=data[8k+7:8k].
//    k<3: k++. k=3: go to DONE. One beat per cycle.
//  - XFER read: ram_re=1, ram_addr=addr+k; go to WAIT.
//  - WAIT: stay RD_LAT cycles. On the last WAIT cycle capture ram_rdata into
//    byte k of the shift register. k<3: k++ and go to XFER. k=3: go to DONE.
//  - DONE: stall_o=0; go to IDLE.
//    For a read, valM_o is updated at DONE entry and is valid during DONE.
//    valM_o holds until the next read completes. Writes and errors leave it unchanged.
//  - stall_o=1 in XFER and WAIT, and in IDLE when a legal request is present.
//    The pipeline advances at the DONE edge.
//  - Stall length: write = 5 cycles; read = 1+4*(1+RD_LAT) cycles (9 at RD_LAT=1).
//  - Request still asserted in the cycle after DONE: treated as a new access.
//    Upstream must present the next op or deassert.
//  - ram_we and ram_re are never both high. Strobes are 0 in IDLE and DONE.
//  - Inputs are ignored outside IDLE (latched copies are used).
//  - Reset mid-operation: next cycle IDLE with all outputs at reset values.
//    Bytes already written stay in RAM (no rollback).
//  - Unaligned addresses are legal; byte serialisation handles them.
// TESTING
//  1. write 0x12345678 @0x100 -> ram_we 4 cycles: 0x100=78, 0x101=56,
//     0x102=34, 0x103=12; stall_o high 5 cycles.
//  2. RAM preset with test 1 data, read @0x100, RD_LAT=1 -> valM_o=0x12345678
//     in DONE; stall_o high 9 cycles.
//  3. write 0xA1B2C3D4 @0x0103 (unaligned), then read @0x0103 -> 0xA1B2C3D4;
//     bytes 0x103..0x106 = D4,C3,B2,A1.
//  4. read @0xFFFD (MEM_BYTES=65536) or @0xFFFFFFFF -> err_o 1 cycle; no ram
//     strobe; stall_o=0; valM_o unchanged.
//  5. mem_read=mem_write=1 @0x10 -> err_o pulse; no RAM access.
//  6. rst during beat k=2 of write 0xDEADBEEF @0x20 -> next cycle IDLE,
//     stall_o=0, all outputs 0; RAM 0x20=EF, 0x21=BE, 0x22/0x23 untouched.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: serialises 32-bit little-endian Y86 data accesses onto an
// 8-bit synchronous RAM port. The pipeline is held on stall_o while an
// access runs. Illegal requests are rejected with a one-cycle err_o pulse.
module dmem_ctrl #(
    parameter int MEM_BYTES = 65536,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] valM_o,
    output logic        stall_o,
    output logic        err_o,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    input  logic [7:0]  ram_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [1:0]     r_state;
    logic [31:0]    r_addr;
    logic [31:0]    r_data;
    logic           r_wr;
    logic [1:0]     r_k;
    logic [WCW-1:0] r_wcnt;
    logic [31:0]    r_buf;
    logic [31:0]    r_valM;
    logic           r_err;

    logic        w_in_range;
    logic        w_legal;
    logic        w_illegal;
    logic        w_xfer;
    logic        w_last_wait;
    logic [31:0] w_beat_addr;
    logic [7:0]  w_wbyte;

    // The top byte of the word must still fit in RAM. The sum is 33 bits wide,
    // so addresses near 0xFFFFFFFF cannot wrap into range.
    assign w_in_range  = ({1'b0, mem_addr} + 33'd3) < 33'(MEM_BYTES);
    assign w_legal     = (mem_read ^ mem_write) & w_in_range;
    assign w_illegal   = (mem_read | mem_write) & ~w_legal;
    assign w_xfer      = (r_state == S_XFER);
    assign w_last_wait = (r_wcnt == WCW'(RD_LAT - 1));
    assign w_beat_addr = r_addr + {30'd0, r_k};
    assign w_wbyte     = r_data[{r_k, 3'b000} +: 8];

    // Strobes are masked by rst. A reset that lands mid-beat then leaves
    // that byte unwritten.
    assign ram_we    = w_xfer & r_wr & ~rst;
    assign ram_re    = w_xfer & ~r_wr & ~rst;
    assign ram_addr  = w_xfer ? w_beat_addr : 32'd0;
    assign ram_wdata = (w_xfer & r_wr) ? w_wbyte : 8'd0;
    assign stall_o   = w_xfer | (r_state == S_WAIT) | ((r_state == S_IDLE) & w_legal);
    assign valM_o    = r_valM;
    assign err_o     = r_err;

    // Access FSM: accept in IDLE, one byte beat per XFER, read data captured on the last WAIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
            r_k     <= '0;
            r_wcnt  <= '0;
            r_buf   <= '0;
            r_valM  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_legal) begin
                        r_addr  <= mem_addr;
                        r_data  <= mem_data;
                        r_wr    <= mem_write;
                        r_k     <= '0;
                        r_state <= S_XFER;
                    end else if (w_illegal) begin
                        r_err <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (r_wr) begin
                        if (r_k == 2'd3) r_state <= S_DONE;
                        else             r_k     <= r_k + 2'd1;
                    end else begin
                        r_wcnt  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_last_wait) begin
                        // Shifting in from the top puts byte k at [8k+7:8k] after four beats
                        r_buf <= {ram_rdata, r_buf[31:8]};
                        if (r_k == 2'd3) begin
                            r_valM  <= {ram_rdata, r_buf[31:8]};
                            r_state <= S_DONE;
                        end else begin
                            r_k     <= r_k + 2'd1;
                            r_state <= S_XFER;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl with a byte RAM model (RD_LAT=1).
// Expected write beats and read results are queued when an op is issued and
// popped when the DUT produces them.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_data;
    logic [31:0] valM_o;
    logic        stall_o, err_o;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we, ram_re;
    logic [7:0]  ram_rdata = 8'd0;

    logic [7:0]  mem [0:65535];
    logic [39:0] wq[$];     // {addr, byte} expected write beats
    logic [31:0] rq[$];     // expected read results
    logic [31:0] exp_valM;
    int checks = 0;
    int errors = 0;

    dmem_ctrl #(.MEM_BYTES(65536), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .valM_o(valM_o),
        .stall_o(stall_o), .err_o(err_o), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[15:0]] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr[15:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each write beat must match the next queued beat; both strobes high is never allowed
    always @(negedge clk) begin
        if (ram_we && ram_re) chk("we_re_excl", 32'd1, 32'd0);
        if (ram_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {ram_addr[23:0], ram_wdata}, 32'd0);
            end else begin
                logic [39:0] e;
                e = wq.pop_front();
                chk("write_beat", {ram_addr[23:0], ram_wdata}, {e[31:8], e[7:0]});
            end
        end
    end

    // Issues one legal access and runs it to completion; returns the stall length
    task automatic do_op(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         output int n);
        logic [31:0] e;
        n = 0;
        if (wr) for (int b = 0; b < 4; b++) wq.push_back({addr + b, data[8*b +: 8]});
        else begin
            e = {mem[addr[15:0]+16'd3], mem[addr[15:0]+16'd2], mem[addr[15:0]+16'd1], mem[addr[15:0]]};
            rq.push_back(e);
        end
        mem_write = wr; mem_read = ~wr; mem_addr = addr; mem_data = data;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall_o) break;
            n++;
        end
        if (n >= 100) chk("stall_timeout", n, 0);
        if (!wr) begin
            e = rq.pop_front();
            exp_valM = e;
            chk("valM_done", valM_o, e);
        end
        chk("done_strobes", {ram_we, ram_re}, 2'b00);
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issues an illegal request for one cycle and checks the err_o pulse
    task automatic err_op(input logic rd, input logic wr, input logic [31:0] addr);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("err_stall", stall_o, 1'b0);
        chk("err_no_strobe0", {ram_we, ram_re}, 2'b00);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("err_pulse", err_o, 1'b1);
        chk("err_no_strobe1", {ram_we, ram_re}, 2'b00);
        chk("err_valM_held", valM_o, exp_valM);
        @(posedge clk); #1;
        @(negedge clk);
        chk("err_one_cycle", err_o, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h11; mem[16'hFFFD] = 8'h22;
        mem[16'hFFFE] = 8'h33; mem[16'hFFFF] = 8'h44;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data = '0;
        exp_valM = 32'd0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_valM", valM_o, 32'd0);
        chk("rst_ctrl", {stall_o, err_o, ram_we, ram_re}, 4'b0000);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: aligned write, 5-cycle stall
        do_op(1'b1, 32'h100, 32'h1234_5678, n);
        chk("t1_stall", n, 5);
        chk("t1_mem", {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]}, 32'h1234_5678);

        // 2: read it back, 9-cycle stall
        do_op(1'b0, 32'h100, 32'h0, n);
        chk("t2_stall", n, 9);
        chk("t2_valM", valM_o, 32'h1234_5678);

        // 3: unaligned write then read
        do_op(1'b1, 32'h103, 32'hA1B2_C3D4, n);
        chk("t3_wstall", n, 5);
        chk("t3_mem", {mem[16'h106], mem[16'h105], mem[16'h104], mem[16'h103]}, 32'hA1B2_C3D4);
        do_op(1'b0, 32'h103, 32'h0, n);
        chk("t3_rstall", n, 9);

        // 4: out-of-range reads, including one that would wrap in 32 bits
        err_op(1'b1, 1'b0, 32'h0000_FFFD);
        err_op(1'b1, 1'b0, 32'hFFFF_FFFF);
        err_op(1'b0, 1'b1, 32'hFFFF_FFFD);

        // Highest legal word address
        do_op(1'b0, 32'h0000_FFFC, 32'h0, n);
        chk("edge_valM", valM_o, 32'h4433_2211);

        // 5: read and write both set
        err_op(1'b1, 1'b1, 32'h10);

        // 6: reset during beat k=2 of a write; only bytes 0 and 1 reach RAM
        wq.push_back({32'h20, 8'hEF});
        wq.push_back({32'h21, 8'hBE});
        mem_write = 1'b1; mem_addr = 32'h20; mem_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;   // k=0
        @(posedge clk); #1;   // k=1
        @(posedge clk); #1;   // k=2
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_write = 1'b0;
        exp_valM = 32'd0;
        @(negedge clk);
        chk("t6_ctrl", {stall_o, err_o, ram_we, ram_re}, 4'b0000);
        chk("t6_ram_addr", ram_addr, 32'd0);
        chk("t6_ram_wdata", ram_wdata, 8'd0);
        chk("t6_valM", valM_o, exp_valM);
        chk("t6_mem", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]}, 32'h0000_BEEF);
        chk("t6_wq_drained", wq.size(), 0);
        @(posedge clk); #1;

        // Controller is usable again after the mid-op reset
        do_op(1'b0, 32'h100, 32'h0, n);
        chk("post_rst_stall", n, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
